// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches and
// drives the IF/ID register, with a one-entry skid for responses landing under stall.
module if_stage #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter int              PC_STEP  = 2,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               pcsrc,
  input  logic [PC_W-1:0]    brc_addr,
  output logic [PC_W-1:0]    pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc_plus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus;
  } ifid_t;

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  state_t            state;
  ifid_t             skid;
  logic [PC_W-1:0]   req_addr;
  logic [PC_W-1:0]   pc_inc;

  assign pc_inc = pc + STEP;

  // DROP keeps presenting the address of the request still in flight
  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = (state == DROP) ? req_addr : pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      skid         <= '0;
      ifid_valid   <= 1'b0;
      ifid_instr   <= '0;
      ifid_pc_plus <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;

        FETCH: begin
          req_addr <= pc;
          if (imem_ready) begin
            if (pcsrc) begin
              pc         <= brc_addr;
              ifid_valid <= 1'b0;
            end else if (stall) begin
              skid  <= '{instr: imem_rdata, pc_plus: pc_inc};
              pc    <= pc_inc;
              state <= HOLD;
            end else begin
              ifid_instr   <= imem_rdata;
              ifid_pc_plus <= pc_inc;
              ifid_valid   <= 1'b1;
              pc           <= pc_inc;
            end
          end else if (pcsrc) begin
            pc         <= brc_addr;
            ifid_valid <= 1'b0;
            state      <= DROP;
          end else if (!stall) begin
            ifid_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (pcsrc) begin
            pc         <= brc_addr;
            ifid_valid <= 1'b0;
            state      <= FETCH;
          end else if (!stall) begin
            ifid_instr   <= skid.instr;
            ifid_pc_plus <= skid.pc_plus;
            ifid_valid   <= 1'b1;
            state        <= FETCH;
          end
        end

        DROP: begin
          // latest redirect wins; the stale response is simply not captured
          if (pcsrc)      pc    <= brc_addr;
          if (imem_ready) state <= FETCH;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: queue-based reference model checked every cycle,
// plus literal expectations at key points of the sequence.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready = 1'b1;
  logic [15:0] imem_rdata;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic [7:0]  brc_addr = 8'h00;
  logic [7:0]  pc;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc_plus;

  int tests = 0;
  int fails = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .pcsrc(pcsrc), .brc_addr(brc_addr), .pc(pc), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc_plus(ifid_pc_plus)
  );

  always #5 clk = ~clk;

  // memory image: mem[A] = A + 16'h1000
  assign imem_rdata = {8'h00, imem_addr} + 16'h1000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [15:0] instr; logic [7:0] pcp; } ent_t;
  ent_t        pend[$];
  bit          m_init = 0, m_up = 0, m_stale = 0;
  logic [7:0]  m_pc = 0, m_raddr = 0, m_pp = 0;
  logic        m_v = 0;
  logic [15:0] m_instr = 0;

  always @(posedge clk) begin
    logic [7:0] nxt;
    if (!rst) begin
      m_init = 1; m_up = 0; m_stale = 0; pend.delete();
      m_pc = 8'h00; m_v = 0; m_instr = 16'h0; m_pp = 8'h00;
    end else if (m_init) begin
      nxt = m_pc + 8'd2;
      if (!m_up) m_up = 1;
      else if (pend.size() != 0) begin
        if (pcsrc) begin pend.delete(); m_pc = brc_addr; m_v = 0; end
        else if (!stall) begin
          m_instr = pend[0].instr; m_pp = pend[0].pcp; m_v = 1; pend.delete();
        end
      end else if (m_stale) begin
        if (pcsrc) m_pc = brc_addr;
        if (imem_ready) m_stale = 0;
      end else begin
        m_raddr = m_pc;
        if (imem_ready) begin
          if (pcsrc) begin m_pc = brc_addr; m_v = 0; end
          else if (stall) begin pend.push_back('{{8'h00, m_pc} + 16'h1000, nxt}); m_pc = nxt; end
          else begin m_instr = {8'h00, m_pc} + 16'h1000; m_pp = nxt; m_v = 1; m_pc = nxt; end
        end else if (pcsrc) begin
          m_pc = brc_addr; m_v = 0; m_stale = 1;
        end else if (!stall) m_v = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_req",   imem_req,     (m_up && pend.size() == 0));
      chk("m_addr",  imem_addr,    m_stale ? m_raddr : m_pc);
      chk("m_pc",    pc,           m_pc);
      chk("m_valid", ifid_valid,   m_v);
      chk("m_instr", ifid_instr,   m_instr);
      chk("m_pcp",   ifid_pc_plus, m_pp);
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct { logic r, rdy, st, ps; logic [7:0] ba; } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic st, input logic ps, input logic [7:0] ba);
    vecs.push_back('{r, rdy, st, ps, ba});
  endtask

  task automatic lit(input int i);
    case (i)
      1:  begin chk("rst_req", imem_req, 0); chk("rst_valid", ifid_valid, 0); chk("rst_pc", pc, 8'h00); end
      3:  begin chk("start_req", imem_req, 1); chk("start_addr", imem_addr, 8'h00); end
      4:  begin chk("i0_valid", ifid_valid, 1); chk("i0_instr", ifid_instr, 16'h1000); chk("i0_pcp", ifid_pc_plus, 8'h02); end
      5:  begin chk("i1_instr", ifid_instr, 16'h1002); chk("i1_pcp", ifid_pc_plus, 8'h04); chk("i1_addr", imem_addr, 8'h04); end
      6:  begin chk("hold_req", imem_req, 0); chk("hold_instr", ifid_instr, 16'h1002); end
      8:  begin chk("hold3_req", imem_req, 0); chk("hold3_instr", ifid_instr, 16'h1002); end
      9:  begin chk("skid_instr", ifid_instr, 16'h1004); chk("skid_pcp", ifid_pc_plus, 8'h06); end
      10: begin chk("i3_instr", ifid_instr, 16'h1006); chk("i3_addr", imem_addr, 8'h08); end
      11: begin chk("br_bubble", ifid_valid, 0); chk("br_addr", imem_addr, 8'h40); end
      12: begin chk("br_instr", ifid_instr, 16'h1040); chk("br_pcp", ifid_pc_plus, 8'h42); chk("br_valid", ifid_valid, 1); end
      14: begin chk("drop_addr", imem_addr, 8'h10); chk("drop_req", imem_req, 1); chk("drop_pc", pc, 8'h20); end
      16: chk("drop_addr3", imem_addr, 8'h10);
      17: begin chk("post_drop_addr", imem_addr, 8'h20); chk("post_drop_valid", ifid_valid, 0); end
      18: chk("tgt_instr", ifid_instr, 16'h1020);
      19: begin chk("flush_stalled", ifid_valid, 0); chk("wrap_addr", imem_addr, 8'hFE); end
      20: begin chk("wrap_instr", ifid_instr, 16'h10FE); chk("wrap_pcp", ifid_pc_plus, 8'h00); chk("wrap_next", imem_addr, 8'h00); end
      22, 25: begin
        chk("mid_rst_valid", ifid_valid, 0); chk("mid_rst_instr", ifid_instr, 0);
        chk("mid_rst_pcp", ifid_pc_plus, 0); chk("mid_rst_pc", pc, 0); chk("mid_rst_req", imem_req, 0);
      end
      26: begin chk("restart_req", imem_req, 1); chk("restart_addr", imem_addr, 8'h00); end
      28: begin chk("wait_hold_valid", ifid_valid, 1); chk("wait_hold_instr", ifid_instr, 16'h1000); end
      29: chk("wait_bubble", ifid_valid, 0);
      30: begin chk("r_instr", ifid_instr, 16'h1002); chk("r_addr", imem_addr, 8'h04); end
      32: begin chk("skid_flush_addr", imem_addr, 8'h50); chk("skid_flush_valid", ifid_valid, 0); end
      34: begin chk("drop2_addr", imem_addr, 8'h52); chk("drop2_pc", pc, 8'h60); end
      35: chk("drop2_latest", pc, 8'h70);
      36: begin chk("drop2_fetch", imem_addr, 8'h70); chk("drop2_valid", ifid_valid, 0); end
      default: ;
    endcase
  endtask

  initial begin
    //   rst rdy st ps  brc
    add(0, 1, 0, 0, 8'h00); add(0, 1, 0, 0, 8'h00);          // reset
    add(1, 1, 0, 0, 8'h00);                                   // IDLE
    add(1, 1, 0, 0, 8'h00); add(1, 1, 0, 0, 8'h00);          // fetch 00, 02
    add(1, 1, 1, 0, 8'h00); add(1, 1, 1, 0, 8'h00); add(1, 1, 1, 0, 8'h00); // stall x3
    add(1, 1, 0, 0, 8'h00); add(1, 1, 0, 0, 8'h00);          // release
    add(1, 1, 0, 1, 8'h40); add(1, 1, 0, 0, 8'h00);          // branch to 40
    add(1, 1, 0, 1, 8'h10);                                   // branch to 10
    add(1, 0, 0, 1, 8'h20); add(1, 0, 0, 0, 8'h00); add(1, 0, 0, 0, 8'h00); // slow + redirect
    add(1, 1, 0, 0, 8'h00); add(1, 1, 0, 0, 8'h00);
    add(1, 1, 1, 1, 8'hFE);                                   // flush while stalled
    add(1, 1, 0, 0, 8'h00); add(1, 1, 1, 0, 8'h00);          // wrap, then HOLD
    add(0, 1, 1, 0, 8'h00);                                   // reset in HOLD
    add(1, 1, 0, 0, 8'h00);                                   // late ready in IDLE
    add(1, 0, 0, 1, 8'h30);                                   // into DROP
    add(0, 0, 0, 0, 8'h00);                                   // reset in DROP
    add(1, 1, 0, 0, 8'h00); add(1, 1, 0, 0, 8'h00);
    add(1, 0, 1, 0, 8'h00); add(1, 0, 0, 0, 8'h00);          // wait w/ stall, then bubble
    add(1, 1, 0, 0, 8'h00); add(1, 1, 1, 0, 8'h00);
    add(1, 1, 1, 1, 8'h50);                                   // flush skid in HOLD
    add(1, 1, 0, 0, 8'h00);
    add(1, 0, 0, 1, 8'h60); add(1, 0, 0, 1, 8'h70);          // double redirect in DROP
    add(1, 1, 0, 0, 8'h00); add(1, 1, 0, 0, 8'h00); add(1, 1, 0, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].r; imem_ready = vecs[i].rdy; stall = vecs[i].st;
      pcsrc = vecs[i].ps; brc_addr = vecs[i].ba;
      @(negedge clk);
      lit(i);
    end
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
